// File: rtl/speed_select_pkg.sv
// speed_select_pkg: shared FSM/direction types and speed bounds for the speed selector.
package speed_select_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKED} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  localparam logic [2:0] SPEED_MIN = 3'd0;
  localparam logic [2:0] SPEED_MAX = 3'd7;
  function automatic logic [2:0] sat_step(input logic [2:0] v, input dir_t dir);
    return dir == DIR_UP ? (v == SPEED_MAX ? v : v + 3'd1) : (v == SPEED_MIN ? v : v - 3'd1);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus consecutive-cycle debounce of one raw button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_level = r_level;
endmodule

// File: rtl/speed_select.sv
// speed_select: debounced up/down buttons drive a saturating 3-bit speed code with auto-repeat.
module speed_select
  import speed_select_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         REPEAT_DELAY    = 12000000,
  parameter int         REPEAT_PERIOD   = 3000000,
  parameter logic [2:0] SPEED_INIT      = 3'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] speed,
  output logic       changed
);
  localparam int TW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic          w_u, w_d, w_rise_u, w_rise_d, w_held, w_other, w_step;
  logic [TW-1:0] w_tmax;
  logic [2:0]    w_next_speed;
  dir_t          w_dir_new;
  logic          r_u_q, r_d_q, r_changed;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_speed;
  state_t        r_state;
  dir_t          r_dir;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset_n(reset_n), .i_raw(btn_up), .o_level(w_u)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset_n(reset_n), .i_raw(btn_down), .o_level(w_d)
  );
  always_comb begin
    w_rise_u     = w_u & ~r_u_q;
    w_rise_d     = w_d & ~r_d_q;
    w_held       = r_dir == DIR_UP ? w_u : w_d;
    w_other      = r_dir == DIR_UP ? w_d : w_u;
    w_tmax       = r_state == DELAY ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1);
    w_dir_new    = r_state == IDLE ? (w_rise_u & ~w_d ? DIR_UP : DIR_DOWN) : r_dir;
    w_step       = r_state == IDLE ? (w_rise_u & ~w_d) | (w_rise_d & ~w_u)
                 : (r_state == DELAY || r_state == REPEAT) && w_held && !w_other && r_timer == w_tmax;
    w_next_speed = w_step ? sat_step(r_speed, w_dir_new) : r_speed;
  end
  // A release or a lock on the same edge as a due repeat wins over the step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_u_q     <= 1'b0;
      r_d_q     <= 1'b0;
      r_speed   <= SPEED_INIT;
      r_changed <= 1'b0;
      r_timer   <= '0;
      r_state   <= IDLE;
      r_dir     <= DIR_UP;
    end else begin
      r_u_q     <= w_u;
      r_d_q     <= w_d;
      r_speed   <= w_next_speed;
      r_changed <= w_next_speed != r_speed;
      case (r_state)
        IDLE:
          if (w_u && w_d) r_state <= LOCKED;
          else if (w_step) begin
            r_state <= DELAY;
            r_dir   <= w_dir_new;
            r_timer <= '0;
          end
        DELAY, REPEAT:
          if (!w_held) r_state <= IDLE;
          else if (w_other) r_state <= LOCKED;
          else if (w_step) begin
            r_state <= REPEAT;
            r_timer <= '0;
          end else r_timer <= r_timer + 1'b1;
        LOCKED:
          if (!w_u && !w_d) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign speed   = r_speed;
  assign changed = r_changed;
endmodule
